// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ write-back requesters.
// Optional macro REGWR_ARB_STATS_EN adds a saturating conflict_count output.
module regfile_write_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             hold,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             regWrite,
  output logic [ADDR_WIDTH-1:0]            writeRegister,
  output logic [DATA_WIDTH-1:0]            writeData,
  output logic [2:0]                       grant_id,
  output logic                             busy
`ifdef REGWR_ARB_STATS_EN
  ,
  output logic [15:0]                      conflict_count
`endif
);

  logic [2:0]            r_rr_ptr;
  logic                  r_regwrite;
  logic [ADDR_WIDTH-1:0] r_write_reg;
  logic [DATA_WIDTH-1:0] r_write_data;
  logic [2:0]            r_grant_id;

  logic                  w_grant;
  logic [2:0]            w_winner;
  logic [2:0]            w_next_ptr;
  logic [NUM_REQ-1:0]    w_ready;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  int unsigned           w_ptr;
  int unsigned           w_dist;
  int unsigned           w_best;

  // Winner is the valid requester at the smallest rotational distance from r_rr_ptr.
  always_comb begin
    w_grant  = 1'b0;
    w_winner = '0;
    w_best   = NUM_REQ;
    w_dist   = 0;
    w_ptr    = 32'(r_rr_ptr);
    if (!reset && !hold) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (req_valid[j]) begin
          w_dist = (j >= w_ptr) ? (j - w_ptr) : (j + NUM_REQ - w_ptr);
          if (w_dist < w_best) begin
            w_best   = w_dist;
            w_grant  = 1'b1;
            w_winner = 3'(j);
          end
        end
      end
    end
  end

  always_comb begin
    w_ready    = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      w_ready[j] = w_grant && (w_winner == 3'(j));
      if (w_ready[j]) begin
        w_sel_addr = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data = req_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    w_next_ptr = (w_winner == 3'(NUM_REQ - 1)) ? 3'd0 : (w_winner + 3'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_regwrite   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_grant_id   <= '0;
    end else if (w_grant) begin
      // Register 0 is hardwired: the slot is consumed but no write is issued.
      r_regwrite   <= (w_sel_addr != '0);
      r_write_reg  <= w_sel_addr;
      r_write_data <= w_sel_data;
      r_grant_id   <= w_winner;
      r_rr_ptr     <= w_next_ptr;
    end else begin
      r_regwrite   <= 1'b0;
    end
  end

`ifdef REGWR_ARB_STATS_EN
  logic [15:0] r_conflict_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict_count <= '0;
    end else if (($countones(req_valid) >= 2) && !hold && (r_conflict_count != 16'hFFFF)) begin
      r_conflict_count <= r_conflict_count + 16'd1;
    end
  end

  assign conflict_count = r_conflict_count;
`endif

  assign req_ready     = w_ready;
  assign regWrite      = r_regwrite;
  assign writeRegister = r_write_reg;
  assign writeData     = r_write_data;
  assign grant_id      = r_grant_id;
  assign busy          = |req_valid;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port between NUM_REQ write-back requesters, such as the ALU write-back, the load unit and a multi-cycle mul/div unit. Each requester uses a valid/ready handshake. The block grants at most one request per cycle using round-robin arbitration and drives a registered regWrite/writeRegister/writeData triple. The outputs update on posedge clk, so they are stable when the register file samples them on negedge clk.

Parameters:
NUM_REQ, 3, number of write-back requesters (2..8).
DATA_WIDTH, 32, write data width.
ADDR_WIDTH, 5, register index width.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous reset, active-high.
hold  input  1  pipeline stall; when 1, no grant is issued this cycle.
req_valid  input  NUM_REQ  per-requester write request.
req_addr  input  NUM_REQ*ADDR_WIDTH  packed destination register; requester i uses slice i.
req_data  input  NUM_REQ*DATA_WIDTH  packed write data; requester i uses slice i.
req_ready  output  NUM_REQ  one-hot grant (combinational); transfer occurs on the posedge where valid&ready.
regWrite  output  1  registered write enable to the register file.
writeRegister  output  ADDR_WIDTH  registered destination index.
writeData  output  DATA_WIDTH  registered write data.
grant_id  output  3  registered index of the requester that produced the current output.
busy  output  1  combinational; 1 when any req_valid is high.

Behaviour:
- Reset (synchronous, at posedge with reset=1):
  - Registered outputs: regWrite=0, writeRegister=0, writeData=0, grant_id=0.
  - rr_ptr=0.
  - req_ready forced to 0 while reset is high.
  - A request in flight during reset is not transferred; the requester keeps it asserted after reset.
- Arbitration (combinational, each cycle):
  - If reset=0 and hold=0 and any req_valid is set, the winner is the first valid index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready[winner]=1; all other bits are 0.
  - No valid request, or hold=1: req_ready is all 0.
- Transfer (posedge, when a grant exists):
  - writeRegister<=req_addr[winner], writeData<=req_data[winner], grant_id<=winner.
  - regWrite<=1 if req_addr[winner]!=0, else 0.
  - A register-0 request is consumed without a write but still uses the slot.
  - rr_ptr<=(winner+1) mod NUM_REQ.
- No grant (posedge): regWrite<=0; writeRegister/writeData/grant_id hold their values; rr_ptr unchanged.
- Latency: a request granted in cycle N appears on the outputs in cycle N+1. The register file writes at the negedge of cycle N+1. Each output write is valid for exactly one cycle.
- Throughput: one write per cycle. Back-to-back grants to the same requester are allowed only when it is the sole valid requester.
- Fairness: with k requesters continuously valid, each is granted within k cycles.
- Same destination from two requesters in one cycle: granted in round-robin order. The later grant's data is the final register value.
- Requester protocol:
  - req_valid must not depend combinationally on req_ready.
  - Once req_valid is asserted, addr/data/valid stay stable until the transfer. The bench asserts this.
- hold is sampled every cycle; hold rising mid-stream suppresses the grant that cycle only.
- grant_id is zero-extended when NUM_REQ<8.

Optional Feature:
REGWR_ARB_STATS_EN:
- Defined: adds output conflict_count [15:0].
  - Increments by 1 at each posedge where at least 2 req_valid bits are high and hold=0.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by reset.
- Undefined: no conflict_count port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, all req_valid=0 -> regWrite=0, writeRegister=0, writeData=0, req_ready=000, busy=0.
- Single requester: req_valid=001, req_addr0=5, req_data0=32'hDEADBEEF -> req_ready=001 the same cycle; next cycle regWrite=1, writeRegister=5, writeData=DEADBEEF, grant_id=0; the cycle after, regWrite=0.
- Round-robin, all three valid continuously after reset (addrs 1/2/3, data 10/20/30):
  - grants cycle through 0,1,2,0.
  - writeRegister sequence 1,2,3,1; each requester is served once every 3 cycles.
- Register zero: req1 addr=0, data=77 -> req_ready[1]=1; next cycle regWrite=0, grant_id=1; rr_ptr advances to 2.
- hold and reset mid-stream, with req0 and req2 valid:
  - hold=1 in cycle 2 -> req_ready=000 in cycle 2, regWrite=0 in cycle 3; arbitration resumes from the same rr_ptr.
  - reset asserted in cycle 5 -> regWrite=0 at cycle 6 and rr_ptr=0, so req0 is granted first after reset.
- REGWR_ARB_STATS_EN: 4 cycles with 2 valid requests, hold=0 -> conflict_count=4; a preloaded 16'hFFFF stays FFFF on further conflicts.
